uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BITWIDTH, default 8, SHALL set the width of every data word.
REQ-002 Parameter TIMEOUT, default 64, legal range 1..65535, SHALL set the maximum cycles to wait for tx_done.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 en  input  1  SHALL enable acceptance of new requests.
REQ-006 req_valid  input  2  SHALL carry per-requester "byte pending" flags; bit i belongs to requester i.
REQ-007 req_data0, req_data1  input  BITWIDTH each  SHALL carry the byte offered by requester 0 and requester 1.
REQ-008 req_ready  output  2  SHALL be the per-requester accept strobe; a byte transfers when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-009 tx_start  output  1  SHALL be the start strobe to the shared transmitter.
REQ-010 tx_data  output  BITWIDTH  SHALL be the byte presented to the transmitter.
REQ-011 tx_done  input  1  SHALL be the transmitter frame-complete pulse.
REQ-012 tx_busy  input  1  SHALL be the transmitter busy flag.
REQ-013 grant  output  2  SHALL be a one-hot indication of the current owner; it is 2'b00 when idle.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-015 err  output  1  SHALL be a one-cycle timeout pulse.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, START and WAIT.
REQ-017 In IDLE, when en=1, tx_busy=0 and req_valid!=0, the block SHALL select winner g using round-robin against register last_grant.
  - Single request: the requesting index wins.
  - Both requesting: the index != last_grant wins.
REQ-018 In the acceptance cycle, req_ready[g] SHALL be 1 combinationally; every other req_ready bit and every other cycle SHALL have req_ready=0.
REQ-019 On the acceptance edge:
  - tx_data <= req_data[g].
  - grant <= one-hot(g).
  - last_grant <= g.
  - State -> START.
REQ-020 In START, tx_start SHALL be 1 for exactly one cycle; state -> WAIT and the timeout counter clears to 0.
REQ-021 In WAIT, tx_done=1 SHALL return the state to IDLE and set grant to 0; otherwise the counter increments.
REQ-022 In WAIT, when the counter reaches TIMEOUT-1 without tx_done, the block SHALL pulse err for one cycle, set grant to 0 and return to IDLE.
REQ-023 Latency: acceptance at edge T SHALL give tx_start high in cycle T+1; tx_done sampled at edge D SHALL allow the next acceptance at edge D+1.
REQ-024 tx_data SHALL hold its value from acceptance until the next acceptance.
REQ-025 tx_done or tx_busy in IDLE or START SHALL be ignored, apart from the IDLE acceptance gating in REQ-017.
REQ-026 en=0 SHALL block only new acceptances; an in-flight byte (START/WAIT) SHALL complete normally.
REQ-027 A requester dropping req_valid before being accepted SHALL lose nothing and SHALL not be granted.
REQ-028 The counter SHALL be 16 bits wide and SHALL never wrap, because WAIT exits at TIMEOUT-1.

Reset
REQ-029 Reset SHALL apply on the edge where rst=1, from any state including mid-frame, and SHALL set:
  - state=IDLE.
  - tx_start=0, tx_data=0.
  - grant=0, err=0, req_ready=0.
  - counter=0.
  - last_grant=1, so requester 0 wins the first tie.
REQ-030 While rst=1, no acceptance SHALL occur.

Verification
REQ-031 Reset, then req_valid=2'b01, req_data0=8'h55 -> req_ready=01 for 1 cycle, tx_start pulse next cycle, tx_data=8'h55, grant=01 until tx_done.
REQ-032 Both valid (8'h55 / 8'h96), tx_done returned 11 cycles after each tx_start -> order 8'h55 (grant 01) then 8'h96 (grant 10); both valids held -> alternation 0,1,0,1.
REQ-033 TIMEOUT=16, tx_done never asserted -> err pulses exactly once, 16 cycles after tx_start; busy=0 and grant=00 the next cycle.
REQ-034 en=0 with req_valid=01 -> req_ready stays 00 indefinitely; set en=1 -> acceptance on the next edge.
REQ-035 rst asserted during WAIT -> next cycle: busy=0, grant=00, tx_start=0, tx_data=0; a later tie grants requester 0.
REQ-036 tx_busy=1 in IDLE with req_valid=11 -> no acceptance until tx_busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and transmitter handshake bundle for uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int BITWIDTH = 8
);
    logic                en;
    logic [1:0]          req_valid;
    logic [BITWIDTH-1:0] req_data0;
    logic [BITWIDTH-1:0] req_data1;
    logic [1:0]          req_ready;
    logic                tx_start;
    logic [BITWIDTH-1:0] tx_data;
    logic                tx_done;
    logic                tx_busy;
    logic [1:0]          grant;
    logic                busy;
    logic                err;

    // Arbiter side
    modport slave (
        input  en, req_valid, req_data0, req_data1, tx_done, tx_busy,
        output req_ready, tx_start, tx_data, grant, busy, err
    );

    // Requester / transmitter / environment side
    modport master (
        output en, req_valid, req_data0, req_data1, tx_done, tx_busy,
        input  req_ready, tx_start, tx_data, grant, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Two-requester round-robin arbiter feeding a shared UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int BITWIDTH = 8,
    parameter int TIMEOUT  = 64
) (
    input  wire                    clk,
    input  wire                    rst,
    uart_tx_arbiter_if.slave       bus
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q;
    logic                tx_start_q;
    logic [BITWIDTH-1:0] tx_data_q;
    logic [1:0]          grant_q;
    logic                last_grant_q;
    logic [15:0]         cnt_q;

    logic                winner;
    logic                accept;
    logic                timeout_hit;
    logic [1:0]          req_ready_d;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        winner = 1'b0;
        case (bus.req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
    end

    always_comb begin
        accept      = !rst && (state_q == ST_IDLE) && bus.en && !bus.tx_busy
                      && (bus.req_valid != 2'b00);
        timeout_hit = !rst && (state_q == ST_WAIT) && !bus.tx_done
                      && (cnt_q == TIMEOUT_LAST);
        req_ready_d = 2'b00;
        if (accept) begin
            req_ready_d = winner ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            cnt_q        <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data_q    <= winner ? bus.req_data1 : bus.req_data0;
                        grant_q      <= winner ? 2'b10 : 2'b01;
                        last_grant_q <= winner;
                        tx_start_q   <= 1'b1;
                        state_q      <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start_q <= 1'b0;
                    cnt_q      <= 16'd0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tx_done || timeout_hit) begin
                        grant_q <= 2'b00;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_start_q <= 1'b0;
                    grant_q    <= 2'b00;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_d;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != ST_IDLE);
    // Combinational so the pulse lands in the last WAIT cycle, before IDLE.
    assign bus.err       = timeout_hit;

endmodule

`default_nettype wire
